// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer: NUM_CH independent prescaled down-counters behind
// one memory-mapped slave, with sticky timeout flags, interrupts and tick pulses.
module multi_interval_timer #(
  parameter  int NUM_CH       = 4,
  parameter  int CNT_W        = 32,
  parameter  int RESET_PERIOD = 49999,
  localparam int ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] tick
);

  logic              wrEn;
  logic [1:0]        word;
  logic [ADDR_W-1:0] chSel;
  logic              unusedWd;

  logic [NUM_CH-1:0] run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
  logic [NUM_CH-1:0] pending_q, pending_d, tick_q, tick_d;
  logic [NUM_CH-1:0] hit, step, timeout;
  logic [7:0]        pre_q    [NUM_CH];
  logic [7:0]        pre_d    [NUM_CH];
  logic [7:0]        pc_q     [NUM_CH];
  logic [7:0]        pc_d     [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  count_q  [NUM_CH];
  logic [CNT_W-1:0]  count_d  [NUM_CH];
  logic [CNT_W-1:0]  snap_q   [NUM_CH];
  logic [CNT_W-1:0]  snap_d   [NUM_CH];
  logic [31:0]       readMux;

  assign wrEn     = chipselect & ~write_n;
  assign word     = address[1:0];
  assign chSel    = address >> 2;
  assign unusedWd = ^writedata;

  // Channel indices at or above NUM_CH never match, so unmapped writes fall away.
  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    assign hit[g]     = wrEn && (chSel == ADDR_W'(g));
    assign step[g]    = run_q[g] && !pending_q[g] && (pc_q[g] == 8'd0);
    assign timeout[g] = step[g] && (count_q[g] == '0);
  end

  assign irq_vec = to_q & ito_q;
  assign irq     = |irq_vec;
  assign tick    = tick_q;

  always_comb begin
    run_d     = run_q;
    to_d      = to_q;
    ito_d     = ito_q;
    cont_d    = cont_q;
    pending_d = '0;
    tick_d    = timeout;
    for (int c = 0; c < NUM_CH; c++) begin
      pre_d[c]    = pre_q[c];
      pc_d[c]     = pc_q[c];
      period_d[c] = period_q[c];
      count_d[c]  = count_q[c];
      snap_d[c]   = snap_q[c];

      // A pending period reload owns the counter for one cycle, ahead of counting.
      if (pending_q[c]) begin
        count_d[c] = period_q[c];
        pc_d[c]    = pre_q[c];
      end else if (run_q[c]) begin
        pc_d[c] = (pc_q[c] == 8'd0) ? pre_q[c] : pc_q[c] - 8'd1;
        if (timeout[c]) begin
          count_d[c] = period_q[c];
        end else if (step[c]) begin
          count_d[c] = count_q[c] - CNT_W'(1);
        end
      end

      if (hit[c] && word == 2'd3) begin
        snap_d[c] = count_q[c];
      end

      if (timeout[c]) begin
        to_d[c] = 1'b1;
      end else if (hit[c] && word == 2'd0 && writedata[0]) begin
        to_d[c] = 1'b0;
      end

      // Later assignments win: START overrides STOP, period-write and one-shot clears.
      if (timeout[c] && !cont_q[c]) begin
        run_d[c] = 1'b0;
      end
      if (hit[c] && word == 2'd2) begin
        period_d[c]  = writedata[CNT_W-1:0];
        pending_d[c] = 1'b1;
        run_d[c]     = 1'b0;
      end
      if (hit[c] && word == 2'd1) begin
        ito_d[c]  = writedata[0];
        cont_d[c] = writedata[1];
        pre_d[c]  = writedata[15:8];
        if (writedata[3]) run_d[c] = 1'b0;
        if (writedata[2]) run_d[c] = 1'b1;
      end
    end
  end

  always_comb begin
    readMux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chSel == ADDR_W'(c)) begin
        case (word)
          2'd0: readMux = {30'd0, run_q[c], to_q[c]};
          2'd1: readMux = {16'd0, pre_q[c], 6'd0, cont_q[c], ito_q[c]};
          2'd2: readMux[CNT_W-1:0] = period_q[c];
          2'd3: readMux[CNT_W-1:0] = snap_q[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata  <= '0;
      run_q     <= '0;
      to_q      <= '0;
      ito_q     <= '0;
      cont_q    <= '0;
      pending_q <= '0;
      tick_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        pre_q[c]    <= '0;
        pc_q[c]     <= '0;
        period_q[c] <= CNT_W'(RESET_PERIOD);
        count_q[c]  <= CNT_W'(RESET_PERIOD);
        snap_q[c]   <= '0;
      end
    end else begin
      readdata  <= readMux;
      run_q     <= run_d;
      to_q      <= to_d;
      ito_q     <= ito_d;
      cont_q    <= cont_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      for (int c = 0; c < NUM_CH; c++) begin
        pre_q[c]    <= pre_d[c];
        pc_q[c]     <= pc_d[c];
        period_q[c] <= period_d[c];
        count_q[c]  <= count_d[c];
        snap_q[c]   <= snap_d[c];
      end
    end
  end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Bench for multi_interval_timer (3 channels): directed scenarios plus random bus
// traffic, every cycle compared against a behavioural per-channel model.
module tb_multi_interval_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  irq_vec;
  logic [2:0]  tick;

  int testsRun  = 0;
  int failCount = 0;

  bit          mRun[3], mTo[3], mIto[3], mCont[3], mPending[3];
  int          mPre[3], mPc[3];
  int unsigned mPeriod[3], mCount[3], mSnap[3];
  logic [2:0]  expTick;
  logic [31:0] expRead;

  multi_interval_timer #(.NUM_CH(3), .CNT_W(32), .RESET_PERIOD(49999)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_vec(irq_vec), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < 3; c++) begin
      mRun[c] = 0; mTo[c] = 0; mIto[c] = 0; mCont[c] = 0; mPending[c] = 0;
      mPre[c] = 0; mPc[c] = 0;
      mPeriod[c] = 49999; mCount[c] = 49999; mSnap[c] = 0;
    end
    expTick = '0;
    expRead = '0;
  endtask

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    logic [31:0] r;
    int ch;
    ch = int'(a[3:2]);
    r  = '0;
    if (ch < 3) begin
      case (a[1:0])
        2'd0: begin r[1] = mRun[ch]; r[0] = mTo[ch]; end
        2'd1: begin r = 32'(mPre[ch]) << 8; r[1] = mCont[ch]; r[0] = mIto[ch]; end
        2'd2: r = mPeriod[ch];
        2'd3: r = mSnap[ch];
      endcase
    end
    return r;
  endfunction

  // One clock of the channel rules, evaluated on the values before the edge.
  task automatic modelStep(input logic [3:0] a, input bit cs, input bit wr, input logic [31:0] d);
    int  ch, w;
    bit  hit, ev, runNext;
    ch = int'(a[3:2]);
    w  = int'(a[1:0]);
    expRead = modelRead(a);
    for (int c = 0; c < 3; c++) begin
      hit = cs && wr && (ch == c);
      ev  = 0;
      if (hit && w == 3) mSnap[c] = mCount[c];
      if (mPending[c]) begin
        mCount[c] = mPeriod[c]; mPc[c] = mPre[c]; mPending[c] = 0;
      end else if (mRun[c]) begin
        if (mPc[c] != 0) mPc[c]--;
        else begin
          mPc[c] = mPre[c];
          if (mCount[c] != 0) mCount[c]--;
          else begin mCount[c] = mPeriod[c]; ev = 1; end
        end
      end
      expTick[c] = ev;
      if (hit && w == 0 && d[0]) mTo[c] = 0;
      if (ev) mTo[c] = 1;
      runNext = mRun[c];
      if (ev && !mCont[c]) runNext = 0;
      if (hit && w == 2) begin mPeriod[c] = d; mPending[c] = 1; runNext = 0; end
      if (hit && w == 1) begin
        if (d[3]) runNext = 0;
        if (d[2]) runNext = 1;
        mIto[c] = d[0]; mCont[c] = d[1]; mPre[c] = int'(d[15:8]);
      end
      mRun[c] = runNext;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input bit cs, input bit wr, input logic [31:0] d);
    logic [2:0] expVec;
    address = a; chipselect = cs; write_n = !wr; writedata = d;
    @(posedge clk);
    if (!reset_n) modelReset();
    else modelStep(a, cs, wr, d);
    #1;
    for (int c = 0; c < 3; c++) expVec[c] = mTo[c] & mIto[c];
    checkOutput("tick", 32'(tick), 32'(expTick));
    checkOutput("irq_vec", 32'(irq_vec), 32'(expVec));
    checkOutput("irq", 32'(irq), 32'(|expVec));
    checkOutput("readdata", readdata, expRead);
  endtask

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(a, 1, 1, d);
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] v);
    applyStimulus(a, 1, 0, 32'd0);
    v = readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'd0, 0, 0, 32'd0);
  endtask

  task automatic waitTick(input int ch, input int limit, output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < limit) begin
      applyStimulus(4'd0, 0, 0, 32'd0);
      n++;
      seen = tick[ch];
    end
    if (!seen) checkOutput("wait_tick_bound", 32'(tick[ch]), 32'd1);
  endtask

  task automatic asyncReset();
    #2;
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_readdata", readdata, 32'd0);
    checkOutput("async_rst_tick", 32'(tick), 32'd0);
    checkOutput("async_rst_irq", 32'(irq), 32'd0);
    idle(2);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    int n, extra;
    logic [3:0]  ra;
    logic [31:0] rd;

    reset_n = 1'b0;
    address = '0; chipselect = 0; write_n = 1; writedata = '0;
    modelReset();
    idle(3);
    reset_n = 1'b1;

    // Reset defaults
    busRead(4'd2, v); checkOutput("rst_period", v, 32'd49999);
    busRead(4'd0, v); checkOutput("rst_status", v, 32'd0);
    busRead(4'd1, v); checkOutput("rst_control", v, 32'd0);
    checkOutput("rst_irq_line", 32'(irq), 32'd0);

    // ch1 continuous, PERIOD=9 PRESCALE=3. pc was reloaded with PRESCALE=0 during the
    // period reload, so the first step is immediate: first tick 1+9*4 = 37 clocks in.
    busWrite(4'd6, 32'd9);
    busWrite(4'd5, 32'h303);
    busWrite(4'd5, 32'h307);
    waitTick(1, 100, n); checkOutput("cont_first_tick", n, 37);
    checkOutput("cont_irq_set", 32'(irq), 32'd1);
    waitTick(1, 100, n); checkOutput("cont_interval", n, 40);
    busWrite(4'd4, 32'd1);
    checkOutput("cont_irq_cleared", 32'(irq), 32'd0);
    waitTick(1, 100, n); checkOutput("cont_interval_after_clear", n, 39);
    checkOutput("cont_irq_reassert", 32'(irq), 32'd1);
    busWrite(4'd5, 32'h30B);

    // ch2 one-shot, PERIOD=5
    busWrite(4'd10, 32'd5);
    busWrite(4'd9, 32'd0);
    busWrite(4'd9, 32'd4);
    waitTick(2, 20, n); checkOutput("oneshot_latency", n, 6);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'd0, 0, 0, 32'd0);
      extra += int'(tick[2]);
    end
    checkOutput("oneshot_single_tick", extra, 0);
    busRead(4'd8, v); checkOutput("oneshot_run_clear", 32'(v[1]), 32'd0);
    busWrite(4'd11, 32'd0);
    busRead(4'd11, v); checkOutput("oneshot_snap", v, 32'd5);

    // ch0 period write while running
    busWrite(4'd1, 32'd4);
    idle(5);
    busWrite(4'd2, 32'd100);
    busRead(4'd0, v); checkOutput("pwrite_run_clear", 32'(v[1]), 32'd0);
    busWrite(4'd3, 32'd0);
    busRead(4'd3, v); checkOutput("pwrite_snap", v, 32'd100);
    busWrite(4'd1, 32'd4);
    waitTick(0, 200, n); checkOutput("pwrite_timeout", n, 101);

    // Collisions on ch2
    busWrite(4'd9, 32'hC);
    busRead(4'd8, v); checkOutput("start_stop_run", 32'(v[1]), 32'd1);
    busWrite(4'd10, 32'd0);
    busWrite(4'd9, 32'h6);
    busRead(4'd8, v); checkOutput("start_beats_reload", 32'(v[1]), 32'd1);
    idle(3);
    busWrite(4'd8, 32'd1);
    busRead(4'd8, v); checkOutput("clear_vs_timeout", 32'(v[0]), 32'd1);
    busWrite(4'd9, 32'h8);

    // Isolation and unmapped channel 3
    busWrite(4'd10, 32'd7);
    busWrite(4'd9, 32'h6);
    busWrite(4'd1, 32'h6);
    for (int i = 12; i < 16; i++) busWrite(4'(i), 32'hFFFF_FFFF);
    for (int i = 12; i < 16; i++) begin
      busRead(4'(i), v); checkOutput("unmapped_read", v, 32'd0);
    end
    busRead(4'd2, v);  checkOutput("iso_ch0_period", v, 32'd100);
    busRead(4'd10, v); checkOutput("iso_ch2_period", v, 32'd7);
    waitTick(2, 50, n);
    waitTick(2, 50, n);  checkOutput("iso_ch2_interval", n, 8);
    waitTick(0, 300, n);
    waitTick(0, 300, n); checkOutput("iso_ch0_interval", n, 101);

    // Random traffic against the model, with an asynchronous reset midway
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        asyncReset();
        busRead(4'd6, v); checkOutput("post_rst_period", v, 32'd49999);
      end
      ra = 4'($urandom_range(0, 15));
      case (ra[1:0])
        2'd1:    rd = ($urandom & 32'hFFFF_00F0) | (32'($urandom_range(0, 2)) << 8) | 32'($urandom_range(0, 15));
        2'd2:    rd = 32'($urandom_range(0, 12));
        default: rd = $urandom;
      endcase
      applyStimulus(ra, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, rd);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/multi_interval_timer.md
# multi_interval_timer

Parametrised multi-channel interval timer, the next generation of the team's single-channel Avalon-MM timer. Provides NUM_CH independent down-counters, each with its own period, 8-bit prescaler, one-shot/continuous mode, sticky timeout flag, interrupt enable and snapshot register, behind one memory-mapped slave. Sits on the system interconnect next to the CPU. Drives a combined interrupt line plus a per-channel interrupt vector and tick pulses for hardware consumers such as the game-tick logic.

## Interface
- NUM_CH, 4: number of channels, 1..8.
- CNT_W, 32: counter and period width, 8..32.
- RESET_PERIOD, 49999: reset value of every channel's period and counter.
- ADDR_W, derived: clog2(NUM_CH)+2. Address = {channel, word[1:0]}.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  OR of irq_vec.
- irq_vec  out  NUM_CH  per-channel irq, equal to TO & ITO.
- tick  out  NUM_CH  one-cycle pulse per channel timeout event.

## Operation
Per-channel word map:
- **0 STATUS**
  - bit0 TO: sticky timeout. Write 1 to clear; writing 0 has no effect.
  - bit1 RUN: read-only.
- **1 CONTROL**
  - bit0 ITO: interrupt enable.
  - bit1 CONT: continuous mode.
  - bit2 START: write-only strobe.
  - bit3 STOP: write-only strobe.
  - bits[15:8] PRESCALE.
  - Reads return ITO, CONT and PRESCALE; bits 2, 3 and the unused bits read 0.
- **2 PERIOD**: CNT_W bits. Upper writedata bits are ignored and read as 0.
- **3 SNAP**: read returns the snapshot. A write of any value captures the live counter into the snapshot.

Reads:
- Reads have no side effects.
- Channel indices at or above NUM_CH read 0, and writes to them are ignored.

Counting:
- While RUN=1, the prescale counter pc decrements every clk.
- When pc==0, pc reloads PRESCALE and the channel "steps". Net step rate is clk/(PRESCALE+1).
- On a step with counter ≠ 0, the counter decrements by 1.
- On a step with counter == 0 (timeout event):
  - counter reloads PERIOD;
  - TO is set;
  - tick pulses;
  - if CONT=0, RUN clears.
- Continuous timeout interval: (PERIOD+1)·(PRESCALE+1) clocks.
- PERIOD=0 with PRESCALE=0 gives a timeout every clock.

Period write (cycle N):
- At the edge ending N: PERIOD is updated, RUN clears, and reload_pending sets.
- At the next edge: counter loads PERIOD, pc loads PRESCALE, and reload_pending clears.

Control write:
- PRESCALE and mode bits update at the edge ending the write cycle.
- START sets RUN. START while already running leaves count and pc untouched.
- STOP clears RUN and freezes count and pc.

Priorities (same cycle):
- START beats STOP.
- START beats a pending period reload's RUN clear; the reload still occurs.
- A timeout event beats a STATUS write-1 clear, so TO stays 1 and no event is lost.
- A CONT=0 timeout coinciding with START leaves RUN=1.
- A snapshot taken in a cycle where the counter changes captures the pre-edge value.

Reset (asynchronous):
- readdata=0, irq=0, irq_vec=0, tick=0.
- Per channel: RUN=0, TO=0, ITO=0, CONT=0, PRESCALE=0, pc=0.
- PERIOD = counter = RESET_PERIOD; snapshot=0.
- A reset asserted mid-count returns to these values immediately. Counting does not resume until START.

## Timing
- readdata is registered: it presents mux(address) one clock after address is applied, and updates every cycle regardless of chipselect.
- Write effects land at the clock edge ending the write cycle. A read issued in the following cycle returns the new value.
- tick and TO are registered and assert at the edge where the counter reloads. irq follows TO combinationally through ITO.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.

## Test plan
- **Reset defaults**: after reset, reading ch0 PERIOD returns 49999; STATUS returns 0; CONTROL returns 0; irq=0.
- **Continuous with prescale** (ch1):
  - Stimulus: PERIOD=9, PRESCALE=3, CONT=1, ITO=1, then START.
  - Required: tick[1] pulses every 40 clocks; irq asserts at the first tick; writing STATUS=1 clears irq; the next tick re-asserts it.
- **One-shot** (ch2):
  - Stimulus: PERIOD=5, PRESCALE=0, CONT=0, then START.
  - Required: exactly one tick, 6 clocks after START's edge; RUN reads 0 afterwards; counter reads back 5 via SNAP.
- **Period write while running** (ch0):
  - Stimulus: write PERIOD=100.
  - Required: RUN=0 next cycle; SNAP write two cycles later returns 100; a subsequent START gives timeout 101 clocks later.
- **Collisions**:
  - START|STOP written together → RUN=1.
  - STATUS clear coinciding with a timeout → TO reads 1.
- **Isolation and unmapped space**:
  - Stimulus: NUM_CH=3; run ch0 and ch2 with different periods; write to channel index 3.
  - Required: independent ticks; channel-3 reads return 0; no other channel's state changes.
